// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs, status codes
// and the writeback run/stop state.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] ICMOVXX = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [3:0] RRSP  = 4'd4;
  localparam logic [3:0] RNONE = 4'd15;
  localparam int NUM_REGS = 15;

  typedef enum logic [1:0] {
    SAOK = 2'd0,
    SADR = 2'd1,
    SINS = 2'd2,
    SHLT = 2'd3
  } stat_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } wb_state_t;

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit architectural register file: two combinational read ports,
// two write ports where port M wins on an address collision.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  src_a_i,
  input  logic [3:0]  src_b_i,
  output logic [63:0] val_a_o,
  output logic [63:0] val_b_o,
  input  logic        we_e_i,
  input  logic [3:0]  dst_e_i,
  input  logic [63:0] val_e_i,
  input  logic        we_m_i,
  input  logic [3:0]  dst_m_i,
  input  logic [63:0] val_m_i
);

  logic [63:0] regs_q [NUM_REGS];

  // NOTE: the array is reset explicitly because software relies on %rsp
  // starting at RSP_INIT and every other register reading 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (4'(i) == RRSP) ? RSP_INIT : 64'd0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values of its inputs.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_m_i && dst_m_i == 4'(i))
          regs_q[i] <= val_m_i;
        else if (we_e_i && dst_e_i == 4'(i))
          regs_q[i] <= val_e_i;
      end
    end
  end

  // No bypass: reads reflect the array as of the last edge.
  assign val_a_o = (src_a_i == RNONE) ? 64'd0 : regs_q[src_a_i];
  assign val_b_o = (src_b_i == RNONE) ? 64'd0 : regs_q[src_b_i];

endmodule

// File: rtl/y86_writeback_regfile.sv
// Y86-64 writeback stage: commits valE/valM, tracks run/stop status,
// counts retired instructions and exposes the decode read ports.
module y86_writeback_regfile
  import y86_pkg::*;
#(
  parameter int          RETIRE_W = 32,
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid,
  input  logic [3:0]          icode,
  input  logic                cnd,
  input  logic [3:0]          dstE,
  input  logic [3:0]          dstM,
  input  logic [63:0]         valE,
  input  logic [63:0]         valM,
  input  logic [1:0]          stat_in,
  input  logic [3:0]          srcA,
  input  logic [3:0]          srcB,
  output logic [63:0]         valA,
  output logic [63:0]         valB,
  output logic [1:0]          stat_out,
  output logic                halted,
  output logic                wb_done,
  output logic [RETIRE_W-1:0] retired
);

  wb_state_t            state_q, state_d;
  stat_t                stat_q, stat_d;
  logic                 done_q, done_d;
  logic [RETIRE_W-1:0]  retired_q, retired_d;
  logic                 we_e, we_m;

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    done_d    = 1'b0;
    retired_d = retired_q;
    we_e      = 1'b0;
    we_m      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (wb_valid) begin
          done_d = 1'b1;
          if (stat_t'(stat_in) == SAOK) begin
            // cmovXX only writes its destination when the condition held
            we_e = (dstE != RNONE) && ((icode != ICMOVXX) || cnd);
            we_m = (dstM != RNONE);
            if (retired_q != '1)
              retired_d = retired_q + 1'b1;
          end else begin
            state_d = ST_STOP;
            stat_d  = stat_t'(stat_in);
          end
        end
      end
      ST_STOP: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      stat_q    <= SAOK;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      done_q    <= done_d;
      retired_q <= retired_d;
    end
  end

  y86_regfile #(.RSP_INIT(RSP_INIT)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .src_a_i (srcA),
    .src_b_i (srcB),
    .val_a_o (valA),
    .val_b_o (valB),
    .we_e_i  (we_e),
    .dst_e_i (dstE),
    .val_e_i (valE),
    .we_m_i  (we_m),
    .dst_m_i (dstM),
    .val_m_i (valM)
  );

  assign stat_out = stat_q;
  assign halted   = (state_q == ST_STOP);
  assign wb_done  = done_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Self-checking bench for y86_writeback_regfile: a reference model feeds
// scoreboard queues of expected status and register contents.
module tb_y86_writeback_regfile;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [3:0]  icode;
  logic        cnd;
  logic [3:0]  dstE, dstM;
  logic [63:0] valE, valM;
  logic [1:0]  stat_in;
  logic [3:0]  srcA, srcB;
  logic [63:0] valA, valB;
  logic [1:0]  stat_out;
  logic        halted;
  logic        wb_done;
  logic [31:0] retired;

  always #5 clk = ~clk;

  y86_writeback_regfile #(.RETIRE_W(32), .RSP_INIT(64'h100)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .icode    (icode),
    .cnd      (cnd),
    .dstE     (dstE),
    .dstM     (dstM),
    .valE     (valE),
    .valM     (valM),
    .stat_in  (stat_in),
    .srcA     (srcA),
    .srcB     (srcB),
    .valA     (valA),
    .valB     (valB),
    .stat_out (stat_out),
    .halted   (halted),
    .wb_done  (wb_done),
    .retired  (retired)
  );

  typedef struct {
    logic        done;
    logic [1:0]  stat;
    logic        halt;
    logic [31:0] ret;
  } exp_st_t;

  typedef struct {
    logic [3:0]  rid;
    logic [63:0] val;
  } exp_reg_t;

  exp_st_t  st_q[$];
  exp_reg_t reg_q[$];

  logic [63:0] mdl [15];
  logic        mdl_stop;
  logic [1:0]  mdl_stat;
  logic [31:0] mdl_ret;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mdl_read(input logic [3:0] rid);
    return (rid == 4'hF) ? 64'd0 : mdl[rid];
  endfunction

  task automatic push_status(input logic done);
    exp_st_t e;
    e.done = done;
    e.stat = mdl_stat;
    e.halt = mdl_stop;
    e.ret  = mdl_ret;
    st_q.push_back(e);
  endtask

  task automatic compare_status(input string tag);
    exp_st_t e;
    if (st_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = st_q.pop_front();
    check({tag, "_wb_done"},  64'(wb_done),  64'(e.done));
    check({tag, "_stat_out"}, 64'(stat_out), 64'(e.stat));
    check({tag, "_halted"},   64'(halted),   64'(e.halt));
    check({tag, "_retired"},  64'(retired),  64'(e.ret));
  endtask

  task automatic expect_reg(input logic [3:0] rid);
    exp_reg_t e;
    e.rid = rid;
    e.val = mdl_read(rid);
    reg_q.push_back(e);
  endtask

  task automatic check_regs(input string tag);
    exp_reg_t e;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      srcA = e.rid;
      srcB = e.rid;
      #1;
      check($sformatf("%s_valA_r%0d", tag, e.rid), valA, e.val);
      check($sformatf("%s_valB_r%0d", tag, e.rid), valB, e.val);
    end
  endtask

  // Caller is at a negedge; returns at a negedge.
  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    wb_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) mdl[i] = (i == 4) ? 64'h100 : 64'd0;
    mdl_stop = 1'b0;
    mdl_stat = 2'd0;
    mdl_ret  = 32'd0;
    push_status(1'b0);
    compare_status(tag);
  endtask

  task automatic commit(input string tag, input logic [3:0] ic, input logic c,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic [1:0] st);
    logic done;
    icode = ic; cnd = c; dstE = de; dstM = dm;
    valE = ve; valM = vm; stat_in = st;
    wb_valid = 1'b1;
    srcA = de;
    srcB = dm;
    #1;
    check({tag, "_nobypass_A"}, valA, mdl_read(de));
    check({tag, "_nobypass_B"}, valB, mdl_read(dm));
    done = !mdl_stop;
    if (!mdl_stop) begin
      if (st == 2'd0) begin
        if (de != 4'hF && (ic != 4'd2 || c)) mdl[de] = ve;
        if (dm != 4'hF) mdl[dm] = vm;
        if (mdl_ret != 32'hFFFF_FFFF) mdl_ret = mdl_ret + 1;
      end else begin
        mdl_stop = 1'b1;
        mdl_stat = st;
      end
    end
    push_status(done);
    @(negedge clk);
    wb_valid = 1'b0;
    compare_status(tag);
    push_status(1'b0);
    @(negedge clk);
    compare_status({tag, "_idle"});
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; icode = '0; cnd = 1'b0;
    dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    stat_in = 2'd0; srcA = 4'hF; srcB = 4'hF;
    @(negedge clk);
    do_reset("reset");
    expect_reg(4'd4); expect_reg(4'd0); expect_reg(4'd15);
    check_regs("reset");

    commit("irmovq", IIRMOVQ, 1'b0, 4'd2, 4'hF, 64'h1234, 64'd0, 2'd0);
    expect_reg(4'd2);
    check_regs("irmovq");

    commit("cmov_nc", ICMOVXX, 1'b0, 4'd5, 4'hF, 64'd7, 64'd0, 2'd0);
    expect_reg(4'd5);
    check_regs("cmov_nc");
    commit("cmov_c", ICMOVXX, 1'b1, 4'd5, 4'hF, 64'd7, 64'd0, 2'd0);
    expect_reg(4'd5);
    check_regs("cmov_c");

    commit("popq_rsp", IPOPQ, 1'b0, 4'd4, 4'd4, 64'h108, 64'hABC, 2'd0);
    expect_reg(4'd4);
    check_regs("popq_rsp");

    commit("mrmovq", IMRMOVQ, 1'b0, 4'hF, 4'd14, 64'd0, 64'hDEAD_BEEF_0000_0001, 2'd0);
    expect_reg(4'd14);
    check_regs("mrmovq");

    for (int k = 0; k < 6; k++) begin
      logic [3:0] de, dm;
      de = 4'($urandom_range(0, 15));
      dm = 4'($urandom_range(0, 15));
      commit($sformatf("rand%0d", k), IOPQ, 1'($urandom), de, dm,
             {$urandom, $urandom}, {$urandom, $urandom}, 2'd0);
      expect_reg(de); expect_reg(dm);
      check_regs($sformatf("rand%0d", k));
    end

    commit("fault", IMRMOVQ, 1'b0, 4'd3, 4'hF, 64'd9, 64'd0, 2'd1);
    expect_reg(4'd3);
    check_regs("fault");
    commit("after_stop", IIRMOVQ, 1'b0, 4'd3, 4'hF, 64'd55, 64'd0, 2'd0);
    expect_reg(4'd3);
    check_regs("after_stop");

    do_reset("reset2");
    commit("halt", IHALT, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 2'd3);
    do_reset("reset3");
    for (int i = 0; i < 16; i++) expect_reg(4'(i));
    check_regs("cleared");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/y86_writeback_regfile.md
Name: y86_writeback_regfile

Overview:
- Writeback stage plus architectural register file for the Y86-64 sequential core.
- Sits directly downstream of the memory stage and consumes its valE/valM/stat per instruction.
- Commits valE/valM into 15 x 64-bit registers and supplies decode with two combinational read ports.
- Owns the processor run/stop state: latches the first non-SAOK status and halts further commits.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.
- RSP_INIT, 64'd0, reset value of %rsp (register 4); all other registers reset to 0.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- wb_valid  input  1  one-cycle strobe from the memory stage; the instruction below is ready to commit.
- icode  input  4  instruction code of the committing instruction.
- cnd  input  1  condition result from execute; gates the dstE write for cmovXX (icode 2).
- dstE  input  4  destination register for valE; 4'hF = none.
- dstM  input  4  destination register for valM; 4'hF = none.
- valE  input  64  ALU result.
- valM  input  64  memory read data.
- stat_in  input  2  status from memory stage: 0 SAOK, 1 SADR, 2 SINS, 3 SHLT.
- srcA  input  4  read-port A register ID.
- srcB  input  4  read-port B register ID.
- valA  output  64  register[srcA], or 0 if srcA = 4'hF.
- valB  output  64  register[srcB], or 0 if srcB = 4'hF.
- stat_out  output  2  architectural status; SAOK while running, latched fault code once stopped.
- halted  output  1  high in STOP state.
- wb_done  output  1  one-cycle pulse in the cycle after each accepted wb_valid.
- retired  output  RETIRE_W  count of instructions committed with SAOK.

Behaviour:
- Reset (rst_n low at a clk edge):
  - r0..r14 are set to 0, except r4, which is set to RSP_INIT.
  - State goes to RUN. stat_out = 0, halted = 0, wb_done = 0, retired = 0.
  - Reset overrides any concurrent wb_valid; that instruction is lost.
- Read ports:
  - Purely combinational from the register array.
  - Return the contents as of the last clock edge; there is no write-through bypass.
  - ID 15 reads 0.
- RUN state, wb_valid = 1, stat_in = SAOK:
  - Write valE to dstE if dstE != 15 and (icode != 2 or cnd = 1).
  - Write valM to dstM if dstM != 15.
  - If dstE == dstM (both valid), valM wins. This matches the popq %rsp semantics.
  - retired increments by 1 and saturates at all-ones.
  - wb_done = 1 next cycle.
- RUN state, wb_valid = 1, stat_in != SAOK:
  - No register writes and no retired increment.
  - stat_out latches stat_in, state goes to STOP, halted = 1, wb_done = 1 next cycle.
- RUN state, wb_valid = 0: no change; wb_done = 0.
- STOP state:
  - All wb_valid strobes are ignored: no writes, wb_done stays 0, stat_out is held.
  - Only reset leaves STOP.
- Latency: a committed value is visible on valA/valB in the cycle after the wb_valid edge.
- Undefined icode values are not checked here. Instruction validity arrives already encoded in stat_in.

Decomposition:
- Shared package y86_pkg:
  - icode constants (IHALT=0 … IPOPQ=11).
  - Register IDs RRSP=4, RNONE=15.
  - Stat codes SAOK/SADR/SINS/SHLT (2-bit).
- One sub-module, y86_regfile:
  - 15 x 64 array, 2 combinational read ports, 2 write ports with fixed port-M priority, synchronous active-low reset with RSP_INIT.
  - The top level holds the RUN/STOP FSM, the cmov gating, stat_out, wb_done and retired.

Test Plan:
- Reset then read: rst_n low for one edge with RSP_INIT=64'h100, then srcA=4, srcB=0 -> valA=64'h100, valB=0, stat_out=0, retired=0.
- irmovq commit: wb_valid, icode=3, dstE=2, valE=64'h1234, stat_in=0 -> next cycle srcA=2 gives 64'h1234, wb_done pulses once, retired=1.
- cmov gating: icode=2, dstE=5, valE=7. With cnd=0 -> r5 unchanged. With cnd=1 -> r5=7.
- popq %rsp collision: dstE=4, valE=64'h108, dstM=4, valM=64'hABC -> r4=64'hABC.
- Fault stop: stat_in=1 with dstE=3, valE=9 -> r3 not written, stat_out=1, halted=1, retired unchanged.
  - A later wb_valid with SAOK and dstE=3 -> ignored, wb_done stays 0.
- Halt then reset: stat_in=3 -> stat_out=3, halted=1; rst_n low for one edge -> RUN, stat_out=0, all registers cleared.
